// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings for the CPU-to-ram256x32 access controller.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_WORD  = 2'b10;
  localparam logic [1:0] SZ_DWORD = 2'b11;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_REL  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Halfwords need an even address; words and doublewords need a word boundary.
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] lsb);
    case (size)
      SZ_BYTE: is_aligned = 1'b1;
      SZ_HALF: is_aligned = ~lsb[0];
      default: is_aligned = (lsb == 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// CPU request bus and RAM MOV/MOC handshake bus seen by mem_access_ctrl.
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic              Start;
  logic              RW;
  logic [1:0]        Size;
  logic              Signed;
  logic [ADDR_W-1:0] Addr;
  logic [31:0]       WData;
  logic [31:0]       WDataHi;
  logic [31:0]       RData;
  logic [31:0]       RDataHi;
  logic              Busy;
  logic              Done;
  logic              Err;
  logic              MOV;
  logic              ReadWrite;
  logic [ADDR_W-1:0] Address;
  logic [31:0]       DataIn;
  logic [1:0]        DataType;
  logic [31:0]       DataOut;
  logic              MOC;

  modport master (
    input  Start, RW, Size, Signed, Addr, WData, WDataHi, DataOut, MOC,
    output RData, RDataHi, Busy, Done, Err, MOV, ReadWrite, Address, DataIn, DataType
  );

  modport slave (
    output Start, RW, Size, Signed, Addr, WData, WDataHi, DataOut, MOC,
    input  RData, RDataHi, Busy, Done, Err, MOV, ReadWrite, Address, DataIn, DataType
  );
endinterface

// File: rtl/mem_access_ctrl_sync2.sv
// Generic two-flop synchronizer with synchronous active-low reset.
module sync2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);
  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule

// File: rtl/mem_access_ctrl.sv
// Bus master turning one-cycle CPU load/store requests into ram256x32 MOV/MOC
// handshakes, with doubleword splitting, alignment check, read extension and timeout.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int ADDR_W  = 8
) (
  input  logic               Clk,
  input  logic               Reset_n,
  mem_access_ctrl_if.master  bus
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]        state_q, state_d;
  logic              beat_q, beat_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rw_q, rw_d;
  logic [1:0]        size_q, size_d;
  logic              sgn_q, sgn_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdatahi_q, wdatahi_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [31:0]       datain_q, datain_d;
  logic [1:0]        dtype_q, dtype_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       rdatahi_q, rdatahi_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic              mov_q, mov_d;
  logic              done_q, done_d;
  logic              moc_s;

  sync2 u_moc_sync (
    .clk_i  (Clk),
    .rst_ni (Reset_n),
    .d_i    (bus.MOC),
    .q_o    (moc_s)
  );

  function automatic logic [31:0] extend(input logic [1:0] size, input logic sgn,
                                         input logic [31:0] d);
    case (size)
      SZ_BYTE: extend = {{24{sgn & d[7]}}, d[7:0]};
      SZ_HALF: extend = {{16{sgn & d[15]}}, d[15:0]};
      default: extend = d;
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    cnt_d     = cnt_q;
    rw_d      = rw_q;
    size_d    = size_q;
    sgn_d     = sgn_q;
    addr_d    = addr_q;
    wdatahi_d = wdatahi_q;
    address_d = address_q;
    datain_d  = datain_q;
    dtype_d   = dtype_q;
    rdata_d   = rdata_q;
    rdatahi_d = rdatahi_q;
    busy_d    = busy_q;
    err_d     = err_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.Start) begin
          rw_d      = bus.RW;
          size_d    = bus.Size;
          sgn_d     = bus.Signed;
          addr_d    = bus.Addr;
          wdatahi_d = bus.WDataHi;
          address_d = bus.Addr;
          datain_d  = bus.WData;
          dtype_d   = (bus.Size == SZ_DWORD) ? SZ_WORD : bus.Size;
          beat_d    = 1'b0;
          cnt_d     = '0;
          busy_d    = 1'b1;
          if (is_aligned(bus.Size, bus.Addr[1:0])) begin
            err_d   = 1'b0;
            state_d = ST_REQ;
          end else begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_REQ: begin
        if (moc_s) begin
          if (rw_q == RW_READ) begin
            if (beat_q) rdatahi_d = bus.DataOut;
            else        rdata_d   = extend(size_q, sgn_q, bus.DataOut);
          end
          cnt_d   = '0;
          state_d = ST_REL;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_REL: begin
        if (!moc_s) begin
          // Second beat of a doubleword targets the next word, wrapping at the top of RAM.
          if (size_q == SZ_DWORD && !beat_q) begin
            beat_d    = 1'b1;
            address_d = addr_q + ADDR_W'(4);
            datain_d  = wdatahi_q;
            cnt_d     = '0;
            state_d   = ST_REQ;
          end else begin
            state_d = ST_DONE;
          end
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    mov_d  = (state_d == ST_REQ);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q   <= ST_IDLE;
      beat_q    <= 1'b0;
      cnt_q     <= '0;
      rw_q      <= 1'b0;
      size_q    <= 2'b00;
      sgn_q     <= 1'b0;
      addr_q    <= '0;
      wdatahi_q <= '0;
      address_q <= '0;
      datain_q  <= '0;
      dtype_q   <= 2'b00;
      rdata_q   <= '0;
      rdatahi_q <= '0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      mov_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      cnt_q     <= cnt_d;
      rw_q      <= rw_d;
      size_q    <= size_d;
      sgn_q     <= sgn_d;
      addr_q    <= addr_d;
      wdatahi_q <= wdatahi_d;
      address_q <= address_d;
      datain_q  <= datain_d;
      dtype_q   <= dtype_d;
      rdata_q   <= rdata_d;
      rdatahi_q <= rdatahi_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      mov_q     <= mov_d;
      done_q    <= done_d;
    end
  end

  assign bus.RData     = rdata_q;
  assign bus.RDataHi   = rdatahi_q;
  assign bus.Busy      = busy_q;
  assign bus.Done      = done_q;
  assign bus.Err       = err_q;
  assign bus.MOV       = mov_q;
  assign bus.ReadWrite = rw_q;
  assign bus.Address   = address_q;
  assign bus.DataIn    = datain_q;
  assign bus.DataType  = dtype_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a byte-addressed RAM model and beat/result scoreboards.
module tb_mem_access_ctrl;
  logic clk;
  logic rst_n;

  mem_access_ctrl_if #(.ADDR_W(8)) bus ();

  mem_access_ctrl #(.TIMEOUT(8), .ADDR_W(8)) dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] din;
    logic [1:0]  dt;
    logic        rw;
  } beat_t;

  typedef struct {
    logic [31:0] rd;
    logic [31:0] rdh;
    logic        err;
  } res_t;

  beat_t exp_beats[$];
  res_t  exp_res[$];
  logic [7:0] mem [256];
  logic moc_en;
  int nchk = 0;
  int nfail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_beat(input logic [7:0] a, input logic [31:0] d, input logic [1:0] dt,
                           input logic rw);
    beat_t b;
    b.addr = a; b.din = d; b.dt = dt; b.rw = rw;
    exp_beats.push_back(b);
  endtask

  task automatic push_res(input logic [31:0] rd, input logic [31:0] rdh, input logic err);
    res_t r;
    r.rd = rd; r.rdh = rdh; r.err = err;
    exp_res.push_back(r);
  endtask

  function automatic logic [31:0] mem_rd(input logic [7:0] a, input logic [1:0] dt);
    case (dt)
      2'b00:   mem_rd = {24'h0, mem[a]};
      2'b01:   mem_rd = {16'h0, mem[a + 8'd1], mem[a]};
      default: mem_rd = {mem[a + 8'd3], mem[a + 8'd2], mem[a + 8'd1], mem[a]};
    endcase
  endfunction

  // RAM model: every MOV rise is checked against the next expected beat.
  initial begin
    beat_t b;
    bus.MOC = 1'b0;
    bus.DataOut = '0;
    forever begin
      @(posedge bus.MOV);
      if (exp_beats.size() == 0) begin
        check("unexpected_mov", {56'h0, bus.Address}, 64'hFFFF);
      end else begin
        b = exp_beats.pop_front();
        check("beat.addr", {56'h0, bus.Address}, {56'h0, b.addr});
        check("beat.din", {32'h0, bus.DataIn}, {32'h0, b.din});
        check("beat.dtype", {62'h0, bus.DataType}, {62'h0, b.dt});
        check("beat.rw", {63'h0, bus.ReadWrite}, {63'h0, b.rw});
      end
      if (moc_en) begin
        #2;
        if (bus.ReadWrite) begin
          bus.DataOut = mem_rd(bus.Address, bus.DataType);
        end else begin
          mem[bus.Address] = bus.DataIn[7:0];
          if (bus.DataType != 2'b00) mem[bus.Address + 8'd1] = bus.DataIn[15:8];
          if (bus.DataType == 2'b10) begin
            mem[bus.Address + 8'd2] = bus.DataIn[23:16];
            mem[bus.Address + 8'd3] = bus.DataIn[31:24];
          end
        end
        bus.MOC = 1'b1;
        wait (bus.MOV == 1'b0);
        #2 bus.MOC = 1'b0;
      end
    end
  end

  task automatic access(input string tag, input logic rw, input logic [1:0] sz, input logic sgn,
                        input logic [7:0] a, input logic [31:0] wd, input logic [31:0] wdh,
                        input int exp_lat, input int exp_mov);
    int cyc;
    int movc;
    logic seen;
    res_t r;
    @(negedge clk);
    bus.Start = 1'b1; bus.RW = rw; bus.Size = sz; bus.Signed = sgn;
    bus.Addr = a; bus.WData = wd; bus.WDataHi = wdh;
    cyc = 0; movc = 0; seen = 1'b0;
    while (cyc < 200 && !seen) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) bus.Start = 1'b0;
      if (bus.MOV) movc++;
      if (bus.Done) seen = 1'b1;
    end
    check({tag, ".done_seen"}, {63'h0, seen}, 64'h1);
    if (seen) begin
      r = exp_res.pop_front();
      check({tag, ".rdata"}, {32'h0, bus.RData}, {32'h0, r.rd});
      check({tag, ".rdatahi"}, {32'h0, bus.RDataHi}, {32'h0, r.rdh});
      check({tag, ".err"}, {63'h0, bus.Err}, {63'h0, r.err});
      check({tag, ".mov_low_at_done"}, {63'h0, bus.MOV}, 64'h0);
      if (exp_lat >= 0) check({tag, ".latency"}, 64'(cyc), 64'(exp_lat));
      if (exp_mov >= 0) check({tag, ".mov_cycles"}, 64'(movc), 64'(exp_mov));
      @(negedge clk);
      check({tag, ".done_one_cycle"}, {63'h0, bus.Done}, 64'h0);
      check({tag, ".busy_after"}, {63'h0, bus.Busy}, 64'h0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h01] = 8'h80;
    {mem[8'h07], mem[8'h06], mem[8'h05], mem[8'h04]} = 32'hDEADBEEF;
    moc_en = 1'b1;
    rst_n = 1'b0;
    bus.Start = 1'b0; bus.RW = 1'b0; bus.Size = 2'b00; bus.Signed = 1'b0;
    bus.Addr = '0; bus.WData = '0; bus.WDataHi = '0;
    repeat (3) @(negedge clk);
    check("reset.busy", {63'h0, bus.Busy}, 64'h0);
    check("reset.done", {63'h0, bus.Done}, 64'h0);
    check("reset.err", {63'h0, bus.Err}, 64'h0);
    check("reset.mov", {63'h0, bus.MOV}, 64'h0);
    check("reset.rdata", {32'h0, bus.RData}, 64'h0);
    rst_n = 1'b1;

    push_beat(8'h04, 32'h0, 2'b10, 1'b1);
    push_res(32'hDEADBEEF, 32'h0, 1'b0);
    access("word_rd", 1'b1, 2'b10, 1'b0, 8'h04, 32'h0, 32'h0, 7, 3);

    push_beat(8'h01, 32'h0, 2'b00, 1'b1);
    push_res(32'hFFFFFF80, 32'h0, 1'b0);
    access("byte_rd_s", 1'b1, 2'b00, 1'b1, 8'h01, 32'h0, 32'h0, -1, -1);

    push_beat(8'h01, 32'h0, 2'b00, 1'b1);
    push_res(32'h00000080, 32'h0, 1'b0);
    access("byte_rd_u", 1'b1, 2'b00, 1'b0, 8'h01, 32'h0, 32'h0, -1, -1);

    push_beat(8'h06, 32'h0, 2'b01, 1'b1);
    push_res(32'hFFFFDEAD, 32'h0, 1'b0);
    access("half_rd_s", 1'b1, 2'b01, 1'b1, 8'h06, 32'h0, 32'h0, -1, -1);

    push_beat(8'hFC, 32'h11111111, 2'b10, 1'b0);
    push_beat(8'h00, 32'h22222222, 2'b10, 1'b0);
    push_res(32'hFFFFDEAD, 32'h0, 1'b0);
    access("dword_wr", 1'b0, 2'b11, 1'b0, 8'hFC, 32'h11111111, 32'h22222222, -1, 6);

    push_beat(8'hFC, 32'h0, 2'b10, 1'b1);
    push_beat(8'h00, 32'h0, 2'b10, 1'b1);
    push_res(32'h11111111, 32'h22222222, 1'b0);
    access("dword_rd", 1'b1, 2'b11, 1'b0, 8'hFC, 32'h0, 32'h0, -1, -1);

    push_res(32'h11111111, 32'h22222222, 1'b1);
    access("misaligned", 1'b1, 2'b01, 1'b0, 8'h03, 32'h0, 32'h0, 1, 0);

    moc_en = 1'b0;
    push_beat(8'h08, 32'h0, 2'b10, 1'b1);
    push_res(32'h11111111, 32'h22222222, 1'b1);
    access("timeout", 1'b1, 2'b10, 1'b0, 8'h08, 32'h0, 32'h0, 9, 8);
    moc_en = 1'b1;

    push_beat(8'h08, 32'hCAFEF00D, 2'b10, 1'b0);
    push_res(32'h11111111, 32'h22222222, 1'b0);
    access("after_timeout", 1'b0, 2'b10, 1'b0, 8'h08, 32'hCAFEF00D, 32'h0, 7, -1);

    // Reset while the request phase is active.
    push_beat(8'h08, 32'h0, 2'b10, 1'b1);
    @(negedge clk);
    bus.Start = 1'b1; bus.RW = 1'b1; bus.Size = 2'b10; bus.Signed = 1'b0; bus.Addr = 8'h08;
    bus.WData = 32'h0; bus.WDataHi = 32'h0;
    @(negedge clk);
    bus.Start = 1'b0;
    @(negedge clk);
    check("rst_mid.mov_before", {63'h0, bus.MOV}, 64'h1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid.mov", {63'h0, bus.MOV}, 64'h0);
    check("rst_mid.busy", {63'h0, bus.Busy}, 64'h0);
    check("rst_mid.done", {63'h0, bus.Done}, 64'h0);
    check("rst_mid.rdata", {32'h0, bus.RData}, 64'h0);
    check("rst_mid.rdatahi", {32'h0, bus.RDataHi}, 64'h0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    push_beat(8'h08, 32'h0, 2'b10, 1'b1);
    push_res(32'hCAFEF00D, 32'h0, 1'b0);
    access("after_reset", 1'b1, 2'b10, 1'b0, 8'h08, 32'h0, 32'h0, 7, -1);

    repeat (5) @(negedge clk);
    check("beats_left", 64'(exp_beats.size()), 64'h0);
    check("results_left", 64'(exp_res.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", nchk, nfail);
    $finish;
  end
endmodule
